// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control unit: a Moore FSM that sequences fetch, decode
// and per-class execute steps, stretching memory states while mem_ready is low.
module multicycle_controller #(
  parameter int OPCODE_W    = 6,
  parameter int SUPPORT_BNE = 1,
  parameter int STATE_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                iord,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_src,
  output logic                branch,
  output logic                branch_ne,
  output logic                illegal_op,
  output logic [STATE_W-1:0]  state_o
);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t state_q, state_d;

  logic is_beq, is_bne;
  assign is_beq = (opcode == OP_BEQ);
  assign is_bne = (SUPPORT_BNE != 0) && (opcode == OP_BNE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs decode from the state register only, except the strobes that must
  // track the memory handshake in the same cycle and the decode-time illegal flag.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = S_MEMADR;
        end else if (opcode == OP_RTYPE) begin
          state_d = S_EXEC;
        end else if (is_beq || is_bne) begin
          state_d = S_BRANCH;
        end else if (opcode == OP_ADDI) begin
          state_d = S_ADDIEX;
        end else if (opcode == OP_J) begin
          state_d = S_JUMP;
        end else begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = is_beq;
        branch_ne = is_bne && !is_beq;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign state_o = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: an instruction-level model expands each instruction into its
// expected per-cycle control word, including wait states and mid-instruction resets.
module tb_multicycle_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [5:0] opcode, opcode_nb;
  logic       mem_ready, ready_nb;

  logic mem_req, iord, mem_write, ir_write, pc_write, reg_write, reg_dst, mem_to_reg;
  logic alu_src_a, branch, branch_ne, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state_o;

  logic nb_mem_req, nb_iord, nb_mem_write, nb_ir_write, nb_pc_write, nb_reg_write;
  logic nb_reg_dst, nb_mem_to_reg, nb_alu_src_a, nb_branch, nb_branch_ne, nb_illegal_op;
  logic [1:0] nb_alu_src_b, nb_alu_op, nb_pc_src;
  logic [3:0] nb_state_o;

  multicycle_controller #(.OPCODE_W(6), .SUPPORT_BNE(1), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .branch(branch), .branch_ne(branch_ne),
    .illegal_op(illegal_op), .state_o(state_o)
  );

  multicycle_controller #(.OPCODE_W(6), .SUPPORT_BNE(0), .STATE_W(4)) dut_nb (
    .clk(clk), .rst_n(rst_n), .opcode(opcode_nb), .mem_ready(ready_nb),
    .mem_req(nb_mem_req), .iord(nb_iord), .mem_write(nb_mem_write),
    .ir_write(nb_ir_write), .pc_write(nb_pc_write), .reg_write(nb_reg_write),
    .reg_dst(nb_reg_dst), .mem_to_reg(nb_mem_to_reg), .alu_src_a(nb_alu_src_a),
    .alu_src_b(nb_alu_src_b), .alu_op(nb_alu_op), .pc_src(nb_pc_src),
    .branch(nb_branch), .branch_ne(nb_branch_ne), .illegal_op(nb_illegal_op),
    .state_o(nb_state_o)
  );

  logic [21:0] obs;
  assign obs = {state_o, mem_req, iord, mem_write, ir_write, pc_write, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
                branch, branch_ne, illegal_op};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_BNE = 4, K_ADDI = 5,
                 K_J = 6, K_ILL = 7;

  typedef struct packed {
    logic [21:0] exp;
    logic        rdy;
    logic [5:0]  op;
  } cyc_t;

  cyc_t q[$];

  function automatic logic [21:0] mk(input logic [3:0] st, input logic mreq, input logic io,
      input logic mw, input logic irw, input logic pcw, input logic rw, input logic rdst,
      input logic m2r, input logic asa, input logic [1:0] asb, input logic [1:0] aop,
      input logic [1:0] psrc, input logic br, input logic bne, input logic ill);
    return {st, mreq, io, mw, irw, pcw, rw, rdst, m2r, asa, asb, aop, psrc, br, bne, ill};
  endfunction

  task automatic push(input logic [21:0] e, input logic r, input logic [5:0] o);
    cyc_t c;
    c.exp = e;
    c.rdy = r;
    c.op  = o;
    q.push_back(c);
  endtask

  function automatic logic [5:0] op_of(input int kind);
    logic [5:0] o;
    case (kind)
      K_LW:   o = 6'b100011;
      K_SW:   o = 6'b101011;
      K_R:    o = 6'b000000;
      K_BEQ:  o = 6'b000100;
      K_BNE:  o = 6'b000101;
      K_ADDI: o = 6'b001000;
      K_J:    o = 6'b000010;
      default: begin
        do o = 6'($urandom);
        while (o inside {6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd35, 6'd43});
      end
    endcase
    return o;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expands one instruction into the control words it must produce, cycle by cycle.
  task automatic build(input int kind, input int wf, input int wm, input logic [5:0] op);
    q.delete();
    for (int i = 0; i < wf; i++)
      push(mk(4'd0,1,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0), 1'b0, 6'($urandom));
    push(mk(4'd0,1,0,0,1,1,0,0,0,0,2'b01,2'b00,2'b00,0,0,0), 1'b1, 6'($urandom));
    push(mk(4'd1,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,kind == K_ILL), rnd(), op);
    case (kind)
      K_LW: begin
        push(mk(4'd2,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0), rnd(), op);
        for (int i = 0; i < wm; i++)
          push(mk(4'd3,1,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0), 1'b0, op);
        push(mk(4'd3,1,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0), 1'b1, op);
        push(mk(4'd4,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0,0), rnd(), op);
      end
      K_SW: begin
        push(mk(4'd2,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0), rnd(), op);
        for (int i = 0; i < wm; i++)
          push(mk(4'd5,1,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0), 1'b0, op);
        push(mk(4'd5,1,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0), 1'b1, op);
      end
      K_R: begin
        push(mk(4'd6,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0), rnd(), op);
        push(mk(4'd7,0,0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0,0,0), rnd(), op);
      end
      K_BEQ, K_BNE:
        push(mk(4'd8,0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,kind == K_BEQ,kind == K_BNE,0),
             rnd(), op);
      K_ADDI: begin
        push(mk(4'd9,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0), rnd(), op);
        push(mk(4'd10,0,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,0,0,0), rnd(), op);
      end
      K_J:
        push(mk(4'd11,0,0,0,0,1,0,0,0,0,2'b00,2'b00,2'b10,0,0,0), rnd(), op);
      default: ;
    endcase
  endtask

  // abort_at >= 0 pulses rst_n low inside that cycle and abandons the instruction.
  task automatic run_instr(input string name, input int kind, input int wf, input int wm,
                           input int abort_at);
    logic [5:0] op;
    op = op_of(kind);
    build(kind, wf, wm, op);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      mem_ready = q[i].rdy;
      opcode    = q[i].op;
      #1;
      check($sformatf("%s op=%b c%0d", name, op, i), 32'(obs), 32'(q[i].exp));
      $display("%s op=%b cyc %0d state=%0d ready=%b", name, op, i, state_o, mem_ready);
      if (i == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        check($sformatf("%s abort state", name), 32'(state_o), 32'd0);
        check($sformatf("%s abort wr", name), 32'({reg_write, mem_write}), 32'd0);
        #1 rst_n = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'd0; ready_nb = 1'b0; opcode_nb = 6'd0;
    #1;
    check("rst async state", 32'(state_o), 32'd0);
    repeat (2) @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("rst fetch mem_req", 32'(mem_req), 32'd1);
    check("rst fetch alu_src_b", 32'(alu_src_b), 32'd1);
    @(negedge clk);
    #1;
    check("rst hold state", 32'(state_o), 32'd0);
    mem_ready = 1'b0;
    rst_n = 1'b1;

    run_instr("lw", K_LW, 0, 0, -1);
    run_instr("sw_wait3", K_SW, 0, 3, -1);
    run_instr("bne", K_BNE, 0, 0, -1);
    run_instr("r_fwait2", K_R, 2, 0, -1);
    run_instr("seq_r", K_R, 0, 0, -1);
    run_instr("seq_addi", K_ADDI, 0, 0, -1);
    run_instr("seq_j", K_J, 0, 0, -1);
    run_instr("seq_beq", K_BEQ, 0, 0, -1);
    run_instr("illegal", K_ILL, 0, 0, -1);
    run_instr("abort_exec", K_R, 1, 0, 3);
    run_instr("after_abort", K_ADDI, 0, 0, -1);
    run_instr("abort_memwr", K_SW, 0, 3, 4);
    run_instr("abort_memrd", K_LW, 0, 2, 3);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 7);
      run_instr($sformatf("rnd%0d", n), kind, $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end

    // Same bne opcode on the instance built without bne support must decode as illegal.
    @(negedge clk);
    ready_nb = 1'b1; opcode_nb = 6'b000101;
    #1;
    check("nb fetch state", 32'(nb_state_o), 32'd0);
    check("nb fetch ir_write", 32'(nb_ir_write), 32'd1);
    @(negedge clk);
    ready_nb = 1'b0;
    #1;
    check("nb decode state", 32'(nb_state_o), 32'd1);
    check("nb decode illegal", 32'(nb_illegal_op), 32'd1);
    $display("nb bne decode state=%0d illegal=%b", nb_state_o, nb_illegal_op);
    @(negedge clk);
    #1;
    check("nb back to fetch", 32'(nb_state_o), 32'd0);
    check("nb no branch", 32'({nb_branch, nb_branch_ne, nb_illegal_op}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter OPCODE_W, default 6, SHALL set the opcode input width; all opcode constants are OPCODE_W bits wide, zero-extended where wider than 6.
REQ-002 Parameter SUPPORT_BNE, default 1, SHALL enable bne (opcode 000101) decoding; when 0, bne SHALL be treated as illegal.
REQ-003 Parameter STATE_W, default 4, SHALL set the width of the state_o debug output.
REQ-004 clk  input  1  single clock, all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 opcode  input  OPCODE_W  instruction opcode field from the instruction register.
REQ-007 mem_ready  input  1  memory handshake: the current access completes in this cycle.
REQ-008 mem_req  output  1  memory access request.
REQ-009 iord  output  1  memory address source: 0 = PC, 1 = ALUOut.
REQ-010 mem_write, ir_write, pc_write, reg_write  output  1 each  write strobes.
REQ-011 reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath muxes.
REQ-012 alu_src_b  output  2  00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
REQ-013 alu_op  output  2  00 = add, 01 = subtract, 10 = funct-decoded.
REQ-014 pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-015 branch, branch_ne  output  1 each  conditional PC write enables (beq, bne).
REQ-016 illegal_op  output  1  one-cycle pulse on an undecodable opcode.
REQ-017 state_o  output  STATE_W  current state encoding.

Function
REQ-018 The block SHALL be a Moore FSM with encoded states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL return to FETCH on the next edge with all strobes 0.
REQ-019 All outputs SHALL be 0 in every state unless listed below; mem_write, ir_write, pc_write and reg_write SHALL never assert in an unlisted state.
REQ-020 FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write and pc_write SHALL equal mem_ready; the FSM SHALL hold in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-021 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state by opcode: lw 100011 or sw 101011 -> MEMADR; R-type 000000 -> EXEC; beq 000100 (and bne 000101 when SUPPORT_BNE=1) -> BRANCH; addi 001000 -> ADDIEX; j 000010 -> JUMP; any other opcode -> FETCH with illegal_op=1 for that one cycle.
REQ-022 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next state MEMRD for lw, MEMWR for sw (opcode held stable by the instruction register).
REQ-023 MEMRD: mem_req=1, iord=1; hold while mem_ready=0; go to MEMWB when mem_ready=1.
REQ-024 MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
REQ-025 MEMWR: mem_req=1, iord=1, mem_write=mem_ready; hold while mem_ready=0; go to FETCH when mem_ready=1.
REQ-026 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.  ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
REQ-027 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01; branch=1 for beq, branch_ne=1 for bne (never both) -> FETCH.
REQ-028 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.  ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
REQ-029 JUMP: pc_src=10, pc_write=1 -> FETCH.
REQ-030 Instruction latency in cycles, with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2; each wait cycle (mem_ready=0 in FETCH, MEMRD or MEMWR) SHALL add exactly one cycle.
REQ-031 mem_ready SHALL be ignored in every state other than FETCH, MEMRD and MEMWR.

Reset
REQ-032 While rst_n=0 the state SHALL be FETCH, immediately and independent of clk.
REQ-033 Assertion of rst_n mid-instruction (including during a memory wait) SHALL abandon the instruction with no further write strobe.
REQ-034 The first rising edge after rst_n deasserts SHALL evaluate FETCH transitions normally.

Verification
REQ-035 Reset, then lw with mem_ready=1 held -> states 0,1,2,3,4,0; reg_write=1 only in state 4, with mem_to_reg=1.
REQ-036 sw with mem_ready=0 for 3 cycles in MEMWR -> FSM holds in state 5; mem_write=0 while waiting; mem_write=1 on exactly one cycle.
REQ-037 Opcode 000101: with SUPPORT_BNE=1 -> BRANCH with branch_ne=1, branch=0; with SUPPORT_BNE=0 -> illegal_op=1 in DECODE, then FETCH.
REQ-038 FETCH with mem_ready=0 for 2 cycles, then 1 -> ir_write and pc_write high on exactly the third cycle, then DECODE.
REQ-039 rst_n pulsed low asynchronously during EXEC -> state_o=0 before the next clk edge; reg_write is never asserted for that instruction.
REQ-040 Sequence R-type, addi, j, beq with mem_ready=1 -> 4+4+3+3 cycles; jump cycle shows pc_src=10, pc_write=1.
